axil_selftest_master: RTL and testbench

- Synthesizable AXI4-Lite master.
- On a start pulse it writes an incrementing pattern to NUM_REGS consecutive 32-bit registers of the downstream AXI4-Lite slave IP, reads every register back and compares each value.
- It reports pass/fail and an error count.
- It sits directly upstream of the slave register block and takes the place of the simulation master VIP in hardware bring-up and on-board self-test.

---
 rtl/axil_selftest_pkg.sv | 26 ++
 rtl/axil_selftest_if.sv | 48 ++++
 rtl/axil_selftest_wdog.sv | 32 +++
 rtl/axil_selftest_master.sv | 226 ++++++++++++++++++++++
 tb/tb_axil_selftest_master.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_selftest_pkg.sv
// Shared types and constants for the AXI4-Lite self-test master:
// FSM state encoding, AXI response codes, register stride and error-counter helper.
package axil_selftest_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_DONE
  } selftest_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Consecutive 32-bit registers sit one word apart.
  localparam int unsigned ADDR_STRIDE = 4;
  localparam int unsigned ERR_WIDTH   = 8;

  // Error counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [ERR_WIDTH-1:0] err_inc(input logic [ERR_WIDTH-1:0] count);
    return (&count) ? count : count + 1'b1;
  endfunction

endpackage

// File: rtl/axil_selftest_if.sv
// AXI4-Lite bus bundle between the self-test master and the slave register block.
// The master modport drives requests; the slave modport drives ready/response.
interface axil_selftest_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;

  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axil_selftest_wdog.sv
// Stall watchdog for the self-test master (built only with AXIL_SELFTEST_TIMEOUT_EN).
// Counts active cycles without a completed handshake; flags the LIMIT-th such cycle.
module axil_selftest_wdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic kick,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!active || kick) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + 1'b1;
    end
  end

  // Fires during the LIMIT-th stalled cycle so the abort lands on the next edge.
  assign expired = active && !kick && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/axil_selftest_master.sv
// AXI4-Lite self-test master: writes SEED+i to NUM_REGS registers, reads them back,
// and reports pass / saturating error count. Define AXIL_SELFTEST_TIMEOUT_EN for the watchdog.
module axil_selftest_master
  import axil_selftest_pkg::*;
#(
  parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned                   C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned                   NUM_REGS           = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0,
  parameter logic [31:0]                   SEED               = 32'h1,
  parameter int unsigned                   TIMEOUT_CYCLES     = 1024
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic                 timeout,
  axil_selftest_if.master      m_axi
);

  localparam int unsigned AW    = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW    = C_M_AXI_DATA_WIDTH;
  localparam int unsigned IDX_W = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  typedef struct packed {
    selftest_state_e      state;
    logic [IDX_W-1:0]     idx;
    logic                 aw_acc;
    logic                 w_acc;
    logic                 awvalid;
    logic                 wvalid;
    logic                 bready;
    logic                 arvalid;
    logic                 rready;
    logic [AW-1:0]        awaddr;
    logic [AW-1:0]        araddr;
    logic [DW-1:0]        wdata;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic                 timeout;
    logic [ERR_WIDTH-1:0] err_count;
  } regs_t;

  regs_t r_q, r_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic last_idx;
  logic wdog_expired;

  function automatic logic [AW-1:0] reg_addr(input logic [IDX_W-1:0] i);
    return BASE_ADDR + AW'(ADDR_STRIDE * i);
  endfunction

  function automatic logic [DW-1:0] reg_data(input logic [IDX_W-1:0] i);
    return DW'(SEED + 32'(i));
  endfunction

  assign aw_hs    = r_q.awvalid && m_axi.awready;
  assign w_hs     = r_q.wvalid  && m_axi.wready;
  assign b_hs     = r_q.bready  && m_axi.bvalid;
  assign ar_hs    = r_q.arvalid && m_axi.arready;
  assign r_hs     = r_q.rready  && m_axi.rvalid;
  assign last_idx = (r_q.idx == LAST_IDX);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  // NOTE: r_d starts as a full copy of r_q and done is cleared before the case,
  // so every field has a value on every path and no latch can be inferred.
  always_comb begin
    r_d      = r_q;
    r_d.done = 1'b0;

    unique case (r_q.state)
      ST_IDLE: begin
        if (start) begin
          r_d.state     = ST_WR_REQ;
          r_d.idx       = '0;
          r_d.err_count = '0;
          r_d.timeout   = 1'b0;
          r_d.pass      = 1'b0;
          r_d.busy      = 1'b1;
          r_d.awvalid   = 1'b1;
          r_d.wvalid    = 1'b1;
          r_d.awaddr    = reg_addr('0);
          r_d.wdata     = reg_data('0);
          r_d.aw_acc    = 1'b0;
          r_d.w_acc     = 1'b0;
        end
      end

      ST_WR_REQ: begin
        // Address and data channels may be accepted in either order.
        if (aw_hs) r_d.awvalid = 1'b0;
        if (w_hs)  r_d.wvalid  = 1'b0;
        r_d.aw_acc = r_q.aw_acc || aw_hs;
        r_d.w_acc  = r_q.w_acc  || w_hs;
        if (r_d.aw_acc && r_d.w_acc) begin
          r_d.aw_acc = 1'b0;
          r_d.w_acc  = 1'b0;
          r_d.bready = 1'b1;
          r_d.state  = ST_WR_RESP;
        end
      end

      ST_WR_RESP: begin
        if (b_hs) begin
          r_d.bready = 1'b0;
          if (m_axi.bresp != RESP_OKAY) r_d.err_count = err_inc(r_q.err_count);
          if (last_idx) begin
            r_d.idx     = '0;
            r_d.arvalid = 1'b1;
            r_d.araddr  = reg_addr('0);
            r_d.state   = ST_RD_REQ;
          end else begin
            r_d.idx     = r_q.idx + 1'b1;
            r_d.awvalid = 1'b1;
            r_d.wvalid  = 1'b1;
            r_d.awaddr  = reg_addr(r_q.idx + 1'b1);
            r_d.wdata   = reg_data(r_q.idx + 1'b1);
            r_d.state   = ST_WR_REQ;
          end
        end
      end

      ST_RD_REQ: begin
        if (ar_hs) begin
          r_d.arvalid = 1'b0;
          r_d.rready  = 1'b1;
          r_d.state   = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        if (r_hs) begin
          r_d.rready = 1'b0;
          // A beat with both bad data and a bad response still counts once.
          if ((m_axi.rdata != reg_data(r_q.idx)) || (m_axi.rresp != RESP_OKAY)) begin
            r_d.err_count = err_inc(r_q.err_count);
          end
          if (last_idx) begin
            r_d.state = ST_DONE;
            r_d.done  = 1'b1;
            r_d.busy  = 1'b0;
            r_d.pass  = (r_d.err_count == '0) && !r_q.timeout;
          end else begin
            r_d.idx     = r_q.idx + 1'b1;
            r_d.arvalid = 1'b1;
            r_d.araddr  = reg_addr(r_q.idx + 1'b1);
            r_d.state   = ST_RD_REQ;
          end
        end
      end

      ST_DONE: begin
        r_d.state = ST_IDLE;
      end

      default: begin
        r_d.state = ST_IDLE;
      end
    endcase

    // Watchdog abort overrides whatever the FSM decided this cycle.
    if (wdog_expired) begin
      r_d.awvalid = 1'b0;
      r_d.wvalid  = 1'b0;
      r_d.bready  = 1'b0;
      r_d.arvalid = 1'b0;
      r_d.rready  = 1'b0;
      r_d.aw_acc  = 1'b0;
      r_d.w_acc   = 1'b0;
      r_d.timeout = 1'b1;
      r_d.state   = ST_DONE;
      r_d.done    = 1'b1;
      r_d.busy    = 1'b0;
      r_d.pass    = 1'b0;
    end
  end

`ifdef AXIL_SELFTEST_TIMEOUT_EN
  axil_selftest_wdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .active  ((r_q.state != ST_IDLE) && (r_q.state != ST_DONE)),
    .kick    (aw_hs || w_hs || b_hs || ar_hs || r_hs),
    .expired (wdog_expired)
  );
`else
  // Without the watchdog the master waits indefinitely for the slave.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign wdog_expired       = 1'b0;
`endif

  assign busy      = r_q.busy;
  assign done      = r_q.done;
  assign pass      = r_q.pass;
  assign err_count = r_q.err_count;
  assign timeout   = r_q.timeout;

  assign m_axi.awaddr  = r_q.awaddr;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = r_q.awvalid;
  assign m_axi.wdata   = r_q.wdata;
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = r_q.wvalid;
  assign m_axi.bready  = r_q.bready;
  assign m_axi.araddr  = r_q.araddr;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = r_q.arvalid;
  assign m_axi.rready  = r_q.rready;

endmodule

// File: tb/tb_axil_selftest_master.sv
// Directed bench for axil_selftest_master: reactive register-slave model with
// configurable stalls/errors and a write/read scoreboard fed by expected transfers.
module tb_axil_selftest_master;
  import axil_selftest_pkg::*;

  localparam int unsigned NREG = 4;
  localparam int unsigned WDOG = 16;

  logic       ACLK    = 1'b0;
  logic       ARESETN = 1'b0;
  logic       start   = 1'b0;
  logic       busy, done, pass, timeout;
  logic [7:0] err_count;

  axil_selftest_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axil_selftest_master #(
    .C_M_AXI_ADDR_WIDTH (32),
    .C_M_AXI_DATA_WIDTH (32),
    .NUM_REGS           (NREG),
    .BASE_ADDR          (32'h0),
    .SEED               (32'h1),
    .TIMEOUT_CYCLES     (WDOG)
  ) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .timeout   (timeout),
    .m_axi     (bus)
  );

  always #5 ACLK = ~ACLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    n_tests++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         wr_exp_q[$];
  logic [31:0] rd_exp_q[$];

  task automatic push_expected();
    for (int i = 0; i < int'(NREG); i++) begin
      wr_exp_q.push_back({32'(4 * i), 32'(1 + i)});
      rd_exp_q.push_back(32'(4 * i));
    end
  endtask

  task automatic sb_write(input logic [31:0] addr, input logic [31:0] data);
    wr_t e;
    check("wr_expected", 128'(wr_exp_q.size() > 0), 128'd1);
    if (wr_exp_q.size() > 0) begin
      e = wr_exp_q.pop_front();
      check("wr_addr", addr, e.addr);
      check("wr_data", data, e.data);
    end
  endtask

  task automatic sb_read(input logic [31:0] addr);
    logic [31:0] e;
    check("rd_expected", 128'(rd_exp_q.size() > 0), 128'd1);
    if (rd_exp_q.size() > 0) begin
      e = rd_exp_q.pop_front();
      check("rd_addr", addr, e);
    end
  endtask

  // ---------------- slave model ----------------
  logic [31:0] mem [NREG];
  int          aw_delay = 0;
  int          w_delay  = 0;
  int          aw_wait, w_wait;
  logic        got_aw, got_w;
  logic [31:0] aw_hold, w_hold;
  logic [31:0] corrupt_addr   = 32'hFFFF_FFF0;
  logic [31:0] bresp_err_addr = 32'hFFFF_FFF0;
  logic [31:0] rresp_err_addr = 32'hFFFF_FFF0;
  logic        ar_block       = 1'b0;

  logic        s_aw_hs, s_w_hs, s_ar_hs, wr_fire;
  logic [31:0] wr_addr, wr_data;

  assign bus.awready = bus.awvalid && !got_aw && (aw_wait >= aw_delay);
  assign bus.wready  = bus.wvalid  && !got_w  && (w_wait  >= w_delay);
  assign bus.arready = bus.arvalid && !ar_block;

  assign s_aw_hs = bus.awvalid && bus.awready;
  assign s_w_hs  = bus.wvalid  && bus.wready;
  assign s_ar_hs = bus.arvalid && bus.arready;
  assign wr_fire = (got_aw || s_aw_hs) && (got_w || s_w_hs);
  assign wr_addr = got_aw ? aw_hold : bus.awaddr;
  assign wr_data = got_w  ? w_hold  : bus.wdata;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      got_aw     <= 1'b0;
      got_w      <= 1'b0;
      aw_wait    <= 0;
      w_wait     <= 0;
      aw_hold    <= '0;
      w_hold     <= '0;
      bus.bvalid <= 1'b0;
      bus.bresp  <= RESP_OKAY;
      bus.rvalid <= 1'b0;
      bus.rdata  <= '0;
      bus.rresp  <= RESP_OKAY;
    end else begin
      aw_wait <= (bus.awvalid && !bus.awready) ? aw_wait + 1 : 0;
      w_wait  <= (bus.wvalid  && !bus.wready)  ? w_wait + 1  : 0;
      if (s_aw_hs) begin
        got_aw  <= 1'b1;
        aw_hold <= bus.awaddr;
      end
      if (s_w_hs) begin
        got_w  <= 1'b1;
        w_hold <= bus.wdata;
      end
      if (wr_fire) begin
        got_aw <= 1'b0;
        got_w  <= 1'b0;
        sb_write(wr_addr, wr_data);
        mem[wr_addr[3:2]] <= wr_data;
        bus.bvalid <= 1'b1;
        bus.bresp  <= (wr_addr == bresp_err_addr) ? RESP_SLVERR : RESP_OKAY;
      end else if (bus.bvalid && bus.bready) begin
        bus.bvalid <= 1'b0;
      end
      if (s_ar_hs) begin
        sb_read(bus.araddr);
        bus.rvalid <= 1'b1;
        bus.rdata  <= (bus.araddr == corrupt_addr) ? 32'hDEAD_BEEF : mem[bus.araddr[3:2]];
        bus.rresp  <= (bus.araddr == rresp_err_addr) ? RESP_SLVERR : RESP_OKAY;
      end else if (bus.rvalid && bus.rready) begin
        bus.rvalid <= 1'b0;
      end
    end
  end

  // ---------------- test sequence helpers ----------------
  task automatic run_test(input string tag, input int exp_err, input logic exp_pass,
                          input bit check_latency, input bit poke_start);
    int cycles;
    push_expected();
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    check({tag, "_busy_rise"}, busy, 1'b1);
    check({tag, "_prot_strb"}, {bus.awprot, bus.arprot, bus.wstrb}, {3'b000, 3'b000, 4'hF});
    cycles = 0;
    while (!done && cycles < 400) begin
      cycles++;
      start = poke_start && (cycles == 5);
      @(negedge ACLK);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, done, 1'b1);
    if (check_latency) check({tag, "_busy_cycles"}, cycles, 16);
    check({tag, "_busy_fall"}, busy, 1'b0);
    check({tag, "_pass"}, pass, exp_pass);
    check({tag, "_err_count"}, err_count, 8'(exp_err));
    check({tag, "_timeout"}, timeout, 1'b0);
    // A start landing while the master sits in DONE must also be ignored.
    start = poke_start;
    @(negedge ACLK);
    start = 1'b0;
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_pass_held"}, pass, exp_pass);
    @(negedge ACLK);
    check({tag, "_idle"}, {busy, bus.awvalid, bus.arvalid}, 3'b000);
    check({tag, "_wr_left"}, wr_exp_q.size(), 0);
    check({tag, "_rd_left"}, rd_exp_q.size(), 0);
    wr_exp_q.delete();
    rd_exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int  cycles;
    bit  saw_done;
    int  ar_cycles;

    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    check("rst_ctrl", {busy, done, pass, timeout, err_count}, '0);
    check("rst_valids", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 5'b0);
    check("rst_addr_data", {bus.awaddr, bus.araddr, bus.wdata}, 96'h0);
    ARESETN = 1'b1;
    @(negedge ACLK);

    // Zero-wait slave.
    run_test("zero_wait", 0, 1'b1, 1'b1, 1'b0);
    check("mem_readback", {mem[0], mem[1], mem[2], mem[3]}, {32'd1, 32'd2, 32'd3, 32'd4});

    // Write address accepted 3 cycles after data, then the reverse.
    aw_delay = 3; w_delay = 0;
    run_test("skew_aw_late", 0, 1'b1, 1'b0, 1'b0);
    aw_delay = 0; w_delay = 3;
    run_test("skew_w_late", 0, 1'b1, 1'b0, 1'b0);
    w_delay = 0;

    // Corrupted readback at 0x8.
    corrupt_addr = 32'h8;
    run_test("corrupt", 1, 1'b0, 1'b1, 1'b0);
    corrupt_addr = 32'hFFFF_FFF0;

    // SLVERR on write 0x4 and on the last read (0xC) with correct data.
    bresp_err_addr = 32'h4;
    rresp_err_addr = 32'hC;
    run_test("err_resp", 2, 1'b0, 1'b1, 1'b0);
    bresp_err_addr = 32'hFFFF_FFF0;
    rresp_err_addr = 32'hFFFF_FFF0;

    // Reset asserted while reading index 2.
    push_expected();
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    cycles = 0;
    while (!(bus.rready && bus.araddr == 32'h8) && cycles < 200) begin
      cycles++;
      @(negedge ACLK);
    end
    check("rst_reach_rd2", {bus.rready, bus.araddr}, {1'b1, 32'h8});
    ARESETN = 1'b0;
    #1;
    check("rst_mid_ctrl", {busy, done, pass, timeout, err_count}, '0);
    check("rst_mid_valids", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 5'b0);
    check("rst_mid_addr_data", {bus.awaddr, bus.araddr, bus.wdata}, 96'h0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge ACLK);
      if (done) saw_done = 1'b1;
    end
    ARESETN = 1'b1;
    @(negedge ACLK);
    if (done) saw_done = 1'b1;
    check("rst_no_done", saw_done, 1'b0);
    check("rst_stay_idle", busy, 1'b0);
    wr_exp_q.delete();
    rd_exp_q.delete();

    // Fresh run after reset, with start pulses that must be ignored.
    run_test("after_rst", 0, 1'b1, 1'b1, 1'b1);

`ifdef AXIL_SELFTEST_TIMEOUT_EN
    // Slave never accepts a read address: watchdog aborts after WDOG cycles.
    ar_block = 1'b1;
    push_expected();
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    cycles    = 0;
    ar_cycles = 0;
    while (!done && cycles < 400) begin
      cycles++;
      if (bus.arvalid) ar_cycles++;
      @(negedge ACLK);
    end
    check("wdog_done_seen", done, 1'b1);
    check("wdog_ar_cycles", ar_cycles, int'(WDOG));
    check("wdog_flags", {timeout, pass, bus.arvalid, busy}, 4'b1000);
    check("wdog_err_count", err_count, 8'd0);
    @(negedge ACLK);
    check("wdog_held", {done, timeout, pass}, 3'b010);
    check("wdog_wr_left", wr_exp_q.size(), 0);
    wr_exp_q.delete();
    rd_exp_q.delete();
    ar_block = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
